// File: rtl/buf_unpack32.sv
// Line-to-word unpacker: streams a 128-bit line as four 32-bit words, low first.
// Optional BUF_UNPACK_PREFETCH_EN adds a one-line prefetch register for gapless lines.
module buf_unpack32 #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int ADR_W  = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [WORD_W*WORDS-1:0]  in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WORD_W-1:0]        out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [ADR_W-1:0]         adr
);

  localparam int LINE_W = WORD_W * WORDS;
  localparam int IDX_W  = $clog2(WORDS);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t             state;
  logic [LINE_W-1:0]  line;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  words [WORDS];

  logic acc;
  logic xfer;
  logic last;
  logic load_in;

  for (genvar i = 0; i < WORDS; i++) begin : g_words
    assign words[i] = line[i*WORD_W +: WORD_W];
  end

  assign out       = words[idx];
  assign out_valid = (state == DRAIN);
  assign last      = (idx == IDX_W'(WORDS - 1));
  assign out_last  = out_valid && last;
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

`ifdef BUF_UNPACK_PREFETCH_EN
  logic [LINE_W-1:0] pf_line;
  logic              pf_valid;
  logic              load_pf;
  logic              pf_wr;

  // Bypass: a stalled-full prefetch frees up as the last word leaves.
  assign in_ready = (state == IDLE) || !pf_valid
                  || (out_last && out_ready);
  assign load_pf  = !clr && xfer && last && pf_valid;
  assign load_in  = !clr && acc
                  && ((state == IDLE) || (xfer && last && !pf_valid));
  assign pf_wr    = !clr && acc && (state == DRAIN)
                  && (!(xfer && last) || pf_valid);
`else
  assign in_ready = (state == IDLE);
  assign load_in  = !clr && acc && (state == IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      adr   <= '0;
`ifdef BUF_UNPACK_PREFETCH_EN
      pf_valid <= 1'b0;
`endif
    end else if (clr) begin
      state <= IDLE;
      idx   <= '0;
      adr   <= '0;
`ifdef BUF_UNPACK_PREFETCH_EN
      pf_valid <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            idx   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // idx wraps to 0 on the last word, which is what a refill needs
          if (xfer) begin
            idx <= idx + 1'b1;
            adr <= adr + 1'b1;
          end
          if (xfer && last) begin
`ifdef BUF_UNPACK_PREFETCH_EN
            if (pf_valid) begin
              pf_valid <= acc;
            end else if (!acc) begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
`ifdef BUF_UNPACK_PREFETCH_EN
          else if (acc) begin
            pf_valid <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
`ifdef BUF_UNPACK_PREFETCH_EN
    if (load_pf) begin
      line <= pf_line;
    end else if (load_in) begin
      line <= in;
    end
    if (pf_wr) begin
      pf_line <= in;
    end
`else
    if (load_in) begin
      line <= in;
    end
`endif
  end

endmodule

// File: doc/buf_unpack32.md
# buf_unpack32

Line-to-word unpacker on the buffer read side: accepts a 128-bit line from a wide buffer (e.g. the output of a 32-to-128 packing buffer) and streams it out as four 32-bit words, low word first, over a valid/ready handshake. It also drives a running 9-bit word address for the downstream consumer. It is the read-side counterpart of the packing buffers: those assemble 32-bit writes into 128-bit lines, and this block disassembles lines back into words.

## Interface
Parameters
- `WORD_W`, 32: output word width.
- `WORDS`, 4: words per line. Line width is `WORD_W*WORDS` = 128.
- `ADR_W`, 9: width of the word address counter.

Ports
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `clr`, in, 1: synchronous abort and clear.
- `in`, in, 128: line data.
- `in_valid`, in, 1: line offered.
- `in_ready`, out, 1: line accepted when `in_valid && in_ready` at the clock edge.
- `out`, out, 32: current word.
- `out_valid`, out, 1: word present.
- `out_ready`, in, 1: word consumed when `out_valid && out_ready` at the clock edge.
- `out_last`, out, 1: current word is word 3 of its line.
- `adr`, out, 9: running index of the word currently on `out`.

## Operation
- Registers:
  - `line` (128): active line.
  - `idx` (2): word select within the active line.
  - `adr` (9).
  - `state`: IDLE or DRAIN.
  - With the prefetch option only: `pf_line` (128) and `pf_valid`.
- `out = line[32*idx +: 32]`.
- `out_valid = (state == DRAIN)`.
- `out_last = out_valid && (idx == 3)`.
- IDLE:
  - On a line accept: `line <= in`, `idx <= 0`, go to DRAIN.
- DRAIN, word transfer:
  - `idx` increments.
  - `adr` increments and wraps from 511 to 0.
- DRAIN, transfer of the last word (`idx == 3`), first matching rule applies:
  - Refill from the prefetch register if it holds a line.
  - Otherwise load a line accepted in the same cycle directly into `line`.
  - Otherwise go to IDLE.
  - In the two refill cases `idx <= 0` and the state stays DRAIN.
- No handshake in a cycle: all state holds. `out` and `out_last` stay stable while `out_valid && !out_ready`.
- `clr` has priority over every other event:
  - State goes to IDLE; `idx`, `adr` and `pf_valid` clear.
  - An accept or transfer in the same cycle is discarded.
  - `in_ready` is computed normally in that cycle, but the accepted line is dropped.
- Data registers `line` and `pf_line` are not reset. Their contents are irrelevant while the corresponding valid is 0.

## Timing
- Values during reset and after release: `state` = IDLE, `out_valid` = 0, `out_last` = 0, `adr` = 0, `idx` = 0, `pf_valid` = 0. `out` is the don't-care line slice.
- `in_ready` after reset: 1.
- Latency: a line accepted at edge N gives `out_valid` = 1 and word 0 on `out` after edge N.
- Throughput with `out_ready` held high: one word per cycle.
  - Without prefetch: 4 words then a 1-cycle bubble, i.e. 4 words per 5 cycles.
  - With prefetch: 4 words per 4 cycles with no bubble, provided `in_valid` stays high.
- `in_ready` is a registered-state function only. It never depends combinationally on `in_valid`.
- With prefetch, `in_ready` may depend on `out_ready` in the last-word cycle (bypass path).
- Reset asserted mid-line: output drops immediately (asynchronously). Partially drained words are lost.

## Configuration
- Macro: `BUF_UNPACK_PREFETCH_EN`.
- Defined:
  - Adds `pf_line` and `pf_valid`.
  - In DRAIN, a line accepted while not on the last-word transfer goes to `pf_line` and sets `pf_valid`.
  - `in_ready = (state == IDLE) || !pf_valid || (out_last && out_ready)`.
  - Refill order on the last-word transfer: `pf_line` first. In that same cycle an incoming line is accepted into `pf_line`.
- Undefined:
  - `in_ready = (state == IDLE)`.
  - The same-cycle bypass path is absent.
  - No prefetch storage.

## Test plan
- Reset then single line:
  - Stimulus: `in` = 0x44444444_33333333_22222222_11111111, `out_ready` = 1.
  - Response: `out` = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; `adr` = 0..3; `out_last` high only on 0x44444444; then `out_valid` = 0 and `in_ready` = 1.
- Backpressure:
  - Stimulus: `out_ready` = 0 for 3 cycles mid-line, at `idx` = 2.
  - Response: `out`, `adr` = 2 and `out_last` = 0 stay stable; the line resumes with no loss or duplication.
- Back-to-back lines, `in_valid` = 1 and `out_ready` = 1 throughout:
  - Without macro: 8 words in 10 cycles, `in_ready` = 0 during DRAIN.
  - With macro: 8 words in 8 consecutive cycles.
- Address wrap:
  - Stimulus: stream 130 lines (520 words).
  - Response: `adr` goes 511 then 0 at word 512 and reads 7 on the final word.
- Clear mid-line:
  - Stimulus: `clr` = 1 at `idx` = 1 with a pending prefetch line and `in_valid` = 1.
  - Response: next cycle `out_valid` = 0, `adr` = 0, the prefetched line is discarded, and the line offered during the `clr` cycle is dropped.
- Asynchronous reset:
  - Stimulus: drop `rst_n` between edges mid-line.
  - Response: `out_valid` falls before the next edge; after release all outputs are at their reset values.
